// File: rtl/hamming_secded_decoder_pipe.sv
// Two-stage SECDED (extended Hamming) decoder with valid/ready on both sides.
// Stage 1 computes syndrome and overall parity; stage 2 classifies, corrects and counts errors.
module hamming_secded_decoder_pipe #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16,
    localparam int R      = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6,
    localparam int N      = DATA_W + R,
    localparam int CODE_W = N + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [R-1:0]      out_syndrome,
    output logic              out_single_err,
    output logic              out_double_err,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              adv1, adv2;

    logic              s1_valid_q, s1_valid_d;
    logic [N-1:0]      s1_code_q, s1_code_d;
    logic [R-1:0]      s1_syn_q, s1_syn_d;
    logic              s1_par_q, s1_par_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [R-1:0]      out_syn_q, out_syn_d;
    logic              out_single_q, out_single_d;
    logic              out_double_q, out_double_d;

    logic [CNT_W-1:0]  corr_q, corr_d;
    logic [CNT_W-1:0]  uncorr_q, uncorr_d;

    logic [R-1:0]      syn_c;
    logic [N-1:0]      fixed_c;
    logic [DATA_W-1:0] data_c;
    logic              single_c, double_c;

    // Each stage may load when it is empty or its content leaves this cycle.
    assign adv2     = !out_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign in_ready = adv1;

    // NOTE: every combinational output gets a default before the loops/branches, so no latch is inferred.
    always_comb begin
        syn_c = '0;
        for (int i = 1; i < CODE_W; i++) begin
            for (int k = 0; k < R; k++) begin
                if (((i >> k) & 1) != 0) begin
                    syn_c[k] = syn_c[k] ^ in_code[i-1];
                end
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        if (adv1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_code_d = in_code[N-1:0];
                s1_syn_d  = syn_c;
                s1_par_d  = ^in_code;
            end
        end
    end

    // S=0 with P=1 matches no position, so only the overall parity bit was wrong.
    always_comb begin
        single_c = 1'b0;
        double_c = 1'b0;
        if (s1_par_q) begin
            if (int'(s1_syn_q) <= N) single_c = 1'b1;
            else                     double_c = 1'b1;
        end else if (s1_syn_q != '0) begin
            double_c = 1'b1;
        end
        fixed_c = s1_code_q;
        for (int i = 1; i <= N; i++) begin
            if (single_c && (s1_syn_q == R'(i))) fixed_c[i-1] = ~fixed_c[i-1];
        end
    end

    always_comb begin
        int j;
        j      = 0;
        data_c = '0;
        for (int i = 1; i <= N; i++) begin
            if ((i & (i - 1)) != 0) begin
                data_c[j] = fixed_c[i-1];
                j++;
            end
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_syn_d    = out_syn_q;
        out_single_d = out_single_q;
        out_double_d = out_double_q;
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d   = data_c;
                out_syn_d    = s1_syn_q;
                out_single_d = single_c;
                out_double_d = double_c;
            end
        end
    end

    // A clear takes priority over an increment in the same cycle.
    always_comb begin
        corr_d   = corr_q;
        uncorr_d = uncorr_q;
        if (cnt_clr) begin
            corr_d   = '0;
            uncorr_d = '0;
        end else if (out_valid_q && out_ready) begin
            if (out_single_q && (corr_q != CNT_MAX))   corr_d   = corr_q + 1'b1;
            if (out_double_q && (uncorr_q != CNT_MAX)) uncorr_d = uncorr_q + 1'b1;
        end
    end

    // NOTE: the data registers are reset too, because outputs must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_code_q    <= '0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_syn_q    <= '0;
            out_single_q <= 1'b0;
            out_double_q <= 1'b0;
            corr_q       <= '0;
            uncorr_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s1_valid_q   <= s1_valid_d;
            s1_code_q    <= s1_code_d;
            s1_syn_q     <= s1_syn_d;
            s1_par_q     <= s1_par_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_syn_q    <= out_syn_d;
            out_single_q <= out_single_d;
            out_double_q <= out_double_d;
            corr_q       <= corr_d;
            uncorr_q     <= uncorr_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_syndrome   = out_syn_q;
    assign out_single_err = out_single_q;
    assign out_double_err = out_double_q;
    assign corr_cnt       = corr_q;
    assign uncorr_cnt     = uncorr_q;

endmodule

// File: tb/tb_hamming_secded_decoder_pipe.sv
// Self-checking bench for hamming_secded_decoder_pipe (DATA_W=8, CNT_W=2): streaming,
// directed error vectors with hand-computed codewords, random back-pressure, and mid-flight reset.
module tb_hamming_secded_decoder_pipe;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;
    localparam int R      = 4;
    localparam int CODE_W = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [R-1:0]      out_syndrome;
    logic              out_single_err;
    logic              out_double_err;
    logic              cnt_clr;
    logic [CNT_W-1:0]  corr_cnt;
    logic [CNT_W-1:0]  uncorr_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] s;
        logic       se;
    } exp_t;

    typedef struct {
        logic [12:0] code;
        logic [7:0]  d;
        logic [3:0]  s;
        logic        se;
        logic        de;
        logic        clr;
        int          corr;
        int          uncorr;
    } vec_t;

    hamming_secded_decoder_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_code        (in_code),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_syndrome   (out_syndrome),
        .out_single_err (out_single_err),
        .out_double_err (out_double_err),
        .cnt_clr        (cnt_clr),
        .corr_cnt       (corr_cnt),
        .uncorr_cnt     (uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference encoder: data at non-power-of-two positions, even parity groups, overall bit on top.
    function automatic logic [12:0] enc(input logic [7:0] d);
        logic [12:0] c;
        logic        x;
        int          j;
        c = '0;
        j = 0;
        for (int p = 1; p <= 12; p++) begin
            if (p != 1 && p != 2 && p != 4 && p != 8) begin
                c[p-1] = d[j];
                j++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            x = 1'b0;
            for (int p = 1; p <= 12; p++) begin
                if (((p >> k) & 1) != 0) x = x ^ c[p-1];
            end
            c[(1 << k) - 1] = x;
        end
        c[12] = ^c[11:0];
        return c;
    endfunction

    task automatic push_word(input logic [12:0] code);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = code;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("push_timeout", 32'(in_ready), 32'(1));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pop_word(input logic clr, output logic [7:0] d, output logic [3:0] s,
                            output logic se, output logic de);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("pop_timeout", 32'(out_valid), 32'(1));
        d         = out_data;
        s         = out_syndrome;
        se        = out_single_err;
        de        = out_double_err;
        out_ready = 1'b1;
        cnt_clr   = clr;
        @(negedge clk);
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[10];
        logic [7:0]  d;
        logic [3:0]  s;
        logic        se, de;
        exp_t        q[$];
        exp_t        cur_exp, e;
        logic [12:0] cur_code;
        logic        have_cur, hold_pend;
        logic [13:0] hold_val;
        int          sent, rcvd, cyc, b;

        // Codewords hand-computed: enc(A5)=0A27, enc(3C)=1362.
        vecs[0] = '{13'h0A37, 8'hA5, 4'd5,  1'b1, 1'b0, 1'b0, 1, 0}; // position 5 flipped
        vecs[1] = '{13'h0A03, 8'hA0, 4'd5,  1'b0, 1'b1, 1'b0, 1, 1}; // positions 3 and 6 flipped
        vecs[2] = '{13'h0B66, 8'hBD, 4'd15, 1'b0, 1'b1, 1'b0, 1, 2}; // S=15 > N with P=1
        vecs[3] = '{13'h1A27, 8'hA5, 4'd0,  1'b1, 1'b0, 1'b0, 2, 2}; // overall bit only
        vecs[4] = '{13'h0A37, 8'hA5, 4'd5,  1'b1, 1'b0, 1'b0, 3, 2};
        vecs[5] = '{13'h0A37, 8'hA5, 4'd5,  1'b1, 1'b0, 1'b0, 3, 2}; // corr saturated
        vecs[6] = '{13'h0B66, 8'hBD, 4'd15, 1'b0, 1'b1, 1'b0, 3, 3};
        vecs[7] = '{13'h0A03, 8'hA0, 4'd5,  1'b0, 1'b1, 1'b0, 3, 3}; // uncorr saturated
        vecs[8] = '{13'h0A27, 8'hA5, 4'd0,  1'b0, 1'b0, 1'b0, 3, 3}; // clean word
        vecs[9] = '{13'h0A37, 8'hA5, 4'd5,  1'b1, 1'b0, 1'b1, 0, 0}; // clear beats increment

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready",  32'(in_ready),  32'(1));
        check("rst_out_data",  32'(out_data),  32'(0));
        check("rst_syndrome",  32'(out_syndrome), 32'(0));
        check("rst_flags",     32'({out_single_err, out_double_err}), 32'(0));
        check("rst_corr",      32'(corr_cnt),   32'(0));
        check("rst_uncorr",    32'(uncorr_cnt), 32'(0));

        // Back-to-back stream: word driven at negedge c appears at negedge c+2.
        out_ready = 1'b1;
        for (int c = 0; c < 258; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                check("stream_valid", 32'(out_valid), 32'(1));
                check("stream_data",  32'(out_data),  32'(c - 2));
                check("stream_flags", 32'({out_single_err, out_double_err}), 32'(0));
            end else begin
                check("stream_fill_valid", 32'(out_valid), 32'(0));
            end
            if (c < 256) begin
                in_valid = 1'b1;
                in_code  = enc(8'(c));
                #1;
                check("stream_in_ready", 32'(in_ready), 32'(1));
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("stream_drained", 32'(out_valid), 32'(0));
        out_ready = 1'b0;

        for (int i = 0; i < 10; i++) begin
            push_word(vecs[i].code);
            pop_word(vecs[i].clr, d, s, se, de);
            check($sformatf("vec%0d_data", i),   32'(d),  32'(vecs[i].d));
            check($sformatf("vec%0d_syn", i),    32'(s),  32'(vecs[i].s));
            check($sformatf("vec%0d_single", i), 32'(se), 32'(vecs[i].se));
            check($sformatf("vec%0d_double", i), 32'(de), 32'(vecs[i].de));
            check($sformatf("vec%0d_corr", i),   32'(corr_cnt),   32'(vecs[i].corr));
            check($sformatf("vec%0d_uncorr", i), 32'(uncorr_cnt), 32'(vecs[i].uncorr));
        end

        // Random back-pressure with occasional single-bit errors; FIFO scoreboard.
        sent      = 0;
        rcvd      = 0;
        cyc       = 0;
        have_cur  = 1'b0;
        hold_pend = 1'b0;
        hold_val  = '0;
        cur_code  = '0;
        cur_exp   = '0;
        while (rcvd < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (hold_pend) begin
                check("stall_hold_valid",  32'(out_valid), 32'(1));
                check("stall_hold_fields", 32'({out_data, out_syndrome, out_single_err, out_double_err}),
                      32'(hold_val));
            end
            if (!have_cur && sent < 1000) begin
                cur_exp.d  = 8'($urandom_range(0, 255));
                cur_code   = enc(cur_exp.d);
                b          = $urandom_range(0, 51);
                cur_exp.s  = 4'd0;
                cur_exp.se = 1'b0;
                if (b < 13) begin
                    cur_code[b] = ~cur_code[b];
                    cur_exp.s   = (b == 12) ? 4'd0 : 4'(b + 1);
                    cur_exp.se  = 1'b1;
                end
                have_cur = 1'b1;
            end
            in_valid  = have_cur && ($urandom_range(0, 3) != 0);
            in_code   = cur_code;
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (in_valid && in_ready) begin
                q.push_back(cur_exp);
                have_cur = 1'b0;
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("stall_unexpected_word", 32'(out_valid), 32'(0));
                end else begin
                    e = q.pop_front();
                    check("stall_data",   32'(out_data),       32'(e.d));
                    check("stall_syn",    32'(out_syndrome),   32'(e.s));
                    check("stall_single", 32'(out_single_err), 32'(e.se));
                    check("stall_double", 32'(out_double_err), 32'(0));
                end
                rcvd++;
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = {out_data, out_syndrome, out_single_err, out_double_err};
        end
        check("stall_received", 32'(rcvd), 32'(1000));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Fill both stages, then reset mid-flight.
        push_word(enc(8'h11));
        push_word(enc(8'h22));
        check("full_out_valid", 32'(out_valid), 32'(1));
        check("full_in_ready",  32'(in_ready),  32'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid),  32'(0));
        check("midrst_in_ready",  32'(in_ready),   32'(1));
        check("midrst_out_data",  32'(out_data),   32'(0));
        check("midrst_corr",      32'(corr_cnt),   32'(0));
        check("midrst_uncorr",    32'(uncorr_cnt), 32'(0));
        @(negedge clk);
        check("midrst_no_ghost",  32'(out_valid),  32'(0));

        push_word(13'h0A37);
        pop_word(1'b0, d, s, se, de);
        check("post_rst_data",   32'(d),  32'(8'hA5));
        check("post_rst_syn",    32'(s),  32'(5));
        check("post_rst_single", 32'(se), 32'(1));
        check("post_rst_corr",   32'(corr_cnt), 32'(1));
        check("post_rst_empty",  32'(out_valid), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
